// File: rtl/ras_pkg.sv
// Return-address-stack shared constants and checkpoint bundle.
// Default DEPTH/WIDTH plus the (ptr, cnt, top) checkpoint struct.
package ras_pkg;

  localparam int RAS_DEPTH = 1024;
  localparam int RAS_WIDTH = 32;
  localparam int RAS_ADDR  = $clog2(RAS_DEPTH);

  typedef struct packed {
    logic [RAS_ADDR-1:0]  ptr;
    logic [RAS_ADDR:0]    cnt;
    logic [RAS_WIDTH-1:0] top;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_bram.sv
// Simple dual-port RAM: port A write, port B registered read.
// Ports: clk, wea/addra/dia (write), enb/addrb -> dob (read, 1-cycle).
module ras_bram #(
  parameter  int DEPTH           = 1024,
  parameter  int WIDTH           = 32,
  parameter  int RESOLVE_COLLIDE = 0,
  localparam int ADDR            = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wea,
  input  logic [ADDR-1:0]  addra,
  input  logic [WIDTH-1:0] dia,
  input  logic             enb,
  input  logic [ADDR-1:0]  addrb,
  output logic [WIDTH-1:0] dob
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wea) mem[addra] <= dia;
  end

  if (RESOLVE_COLLIDE != 0) begin : g_fwd
    always_ff @(posedge clk) begin
      if (enb) dob <= (wea && addra == addrb) ? dia : mem[addrb];
    end
  end else begin : g_raw
    always_ff @(posedge clk) begin
      if (enb) dob <= mem[addrb];
    end
  end

endmodule

// File: rtl/ras_ctrl.sv
// Return address stack: top/next-on-stack in flops, rest in a circular BRAM.
// Ports: clk, rst, push_i/push_addr_i, pop_i -> top_o, empty_o, full_o,
// count_o, overflow_o, underflow_o. RAS_RESTORE_EN adds restore_*/ckpt_*.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter  int DEPTH = RAS_DEPTH,
  parameter  int WIDTH = RAS_WIDTH,
  localparam int ADDR  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_addr_i,
  input  logic             pop_i,
`ifdef RAS_RESTORE_EN
  input  logic             restore_i,
  input  logic [ADDR-1:0]  restore_ptr_i,
  input  logic [ADDR:0]    restore_cnt_i,
  input  logic [WIDTH-1:0] restore_top_i,
  output logic [ADDR-1:0]  ckpt_ptr_o,
  output logic [ADDR:0]    ckpt_cnt_o,
`endif
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [ADDR:0]    count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam logic [ADDR:0] CNT_MAX = (ADDR+1)'(DEPTH);

  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic [WIDTH-1:0] nos_next, dob;
  logic [ADDR-1:0]  wptr_q, wptr_d;
  logic [ADDR:0]    count_q, count_d;
  logic             rd_pend_q, rd_pend_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wea, enb;
  logic [ADDR-1:0]  addrb;
  logic             is_empty, is_full;
  logic             do_rest, do_repl, do_push, do_pop, do_udf;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_MAX);

  always_comb begin
`ifdef RAS_RESTORE_EN
    do_rest = ~rst & restore_i;
`else
    do_rest = 1'b0;
`endif
    do_repl = ~rst & ~do_rest & push_i & pop_i;
    do_push = ~rst & ~do_rest & push_i & ~pop_i;
    do_pop  = ~rst & ~do_rest & ~push_i & pop_i & ~is_empty;
    do_udf  = ~rst & ~do_rest & ~push_i & pop_i & is_empty;
  end

  // A read issued last cycle makes dob the live next-on-stack.
  assign nos_next = rd_pend_q ? dob : nos_q;

  always_comb begin
    top_d     = top_q;
    nos_d     = nos_next;
    wptr_d    = wptr_q;
    count_d   = count_q;
    rd_pend_d = 1'b0;
    ovf_d     = 1'b0;
    udf_d     = 1'b0;
    wea       = 1'b0;
    enb       = 1'b0;
    addrb     = wptr_q - ADDR'(2);
    unique case (1'b1)
`ifdef RAS_RESTORE_EN
      do_rest: begin
        wptr_d    = restore_ptr_i;
        count_d   = restore_cnt_i;
        top_d     = restore_top_i;
        enb       = 1'b1;
        addrb     = restore_ptr_i - ADDR'(1);
        rd_pend_d = 1'b1;
      end
`endif
      do_repl: top_d = push_addr_i;
      do_push: begin
        wea    = 1'b1;
        top_d  = push_addr_i;
        nos_d  = top_q;
        wptr_d = wptr_q + ADDR'(1);
        // When full the write lands on the oldest slot.
        if (is_full) ovf_d   = 1'b1;
        else         count_d = count_q + (ADDR+1)'(1);
      end
      do_pop: begin
        top_d   = (count_q == (ADDR+1)'(1)) ? '0 : nos_next;
        wptr_d  = wptr_q - ADDR'(1);
        count_d = count_q - (ADDR+1)'(1);
        // Prefetch the entry that becomes next-on-stack.
        if (count_q >= (ADDR+1)'(3)) begin
          enb       = 1'b1;
          rd_pend_d = 1'b1;
        end
      end
      do_udf:  udf_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q     <= '0;
      nos_q     <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      rd_pend_q <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      top_q     <= top_d;
      nos_q     <= nos_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      rd_pend_q <= rd_pend_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  ras_bram #(
    .DEPTH          (DEPTH),
    .WIDTH          (WIDTH),
    .RESOLVE_COLLIDE(0)
  ) u_bram (
    .clk  (clk),
    .wea  (wea),
    .addra(wptr_q),
    .dia  (top_q),
    .enb  (enb),
    .addrb(addrb),
    .dob  (dob)
  );

  assign top_o       = top_q;
  assign count_o     = count_q;
  assign empty_o     = is_empty;
  assign full_o      = is_full;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

`ifdef RAS_RESTORE_EN
  assign ckpt_ptr_o = wptr_q;
  assign ckpt_cnt_o = count_q;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl (DEPTH=4): driver queues expectations,
// monitor pops and compares after every clock. RAS_RESTORE_EN adds restore.
module tb_ras_ctrl;
  import ras_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int ADDR  = $clog2(DEPTH);

  typedef struct {
    string            name;
    bit               rst, push, pop, rest;
    logic [WIDTH-1:0] addr;
    logic [ADDR-1:0]  rptr;
    logic [ADDR:0]    rcnt;
    logic [WIDTH-1:0] rtop;
    logic [WIDTH-1:0] top;
    logic [ADDR:0]    cnt;
    bit               ovf, udf;
  } vec_t;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] top;
    logic [ADDR:0]    cnt;
    logic             empty, full, ovf, udf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             push_i;
  logic [WIDTH-1:0] push_addr_i;
  logic             pop_i;
  logic [WIDTH-1:0] top_o;
  logic             empty_o, full_o;
  logic [ADDR:0]    count_o;
  logic             overflow_o, underflow_o;
`ifdef RAS_RESTORE_EN
  logic             restore_i;
  logic [ADDR-1:0]  restore_ptr_i;
  logic [ADDR:0]    restore_cnt_i;
  logic [WIDTH-1:0] restore_top_i;
  logic [ADDR-1:0]  ckpt_ptr_o;
  logic [ADDR:0]    ckpt_cnt_o;
`endif

  vec_t vecs[$];
  exp_t exp_q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ras_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_i),
    .push_addr_i  (push_addr_i),
    .pop_i        (pop_i),
`ifdef RAS_RESTORE_EN
    .restore_i    (restore_i),
    .restore_ptr_i(restore_ptr_i),
    .restore_cnt_i(restore_cnt_i),
    .restore_top_i(restore_top_i),
    .ckpt_ptr_o   (ckpt_ptr_o),
    .ckpt_cnt_o   (ckpt_cnt_o),
`endif
    .top_o        (top_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .count_o      (count_o),
    .overflow_o   (overflow_o),
    .underflow_o  (underflow_o)
  );

  task automatic add(string n, bit r, bit pu, bit po,
                     logic [WIDTH-1:0] a, logic [WIDTH-1:0] t,
                     int c, bit o, bit u);
    vec_t x;
    x.name = n;  x.rst = r;  x.push = pu; x.pop = po;
    x.rest = 1'b0; x.addr = a;
    x.rptr = '0; x.rcnt = '0; x.rtop = '0;
    x.top = t; x.cnt = (ADDR+1)'(c); x.ovf = o; x.udf = u;
    vecs.push_back(x);
  endtask

  task automatic add_rs(string n, int p, int rc, logic [WIDTH-1:0] rt,
                        logic [WIDTH-1:0] t, int c);
    vec_t x;
    x.name = n;  x.rst = 1'b0; x.push = 1'b0; x.pop = 1'b0;
    x.rest = 1'b1; x.addr = '0;
    x.rptr = ADDR'(p); x.rcnt = (ADDR+1)'(rc); x.rtop = rt;
    x.top = t; x.cnt = (ADDR+1)'(c); x.ovf = 1'b0; x.udf = 1'b0;
    vecs.push_back(x);
  endtask

  // Monitor: compare one queued expectation after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (top_o !== e.top || count_o !== e.cnt ||
            empty_o !== e.empty || full_o !== e.full ||
            overflow_o !== e.ovf || underflow_o !== e.udf) begin
          n_fail++;
          $display("FAIL %s: got top=%h cnt=%0d e=%b f=%b o=%b u=%b, want top=%h cnt=%0d e=%b f=%b o=%b u=%b",
                   e.name, top_o, count_o, empty_o, full_o,
                   overflow_o, underflow_o, e.top, e.cnt,
                   e.empty, e.full, e.ovf, e.udf);
        end
      end
    end
  end

  initial begin
    exp_t x;
    rst = 1'b1; push_i = 1'b0; pop_i = 1'b0; push_addr_i = '0;
`ifdef RAS_RESTORE_EN
    restore_i = 1'b0; restore_ptr_i = '0;
    restore_cnt_i = '0; restore_top_i = '0;
`endif
    //  name        rst pu po addr    top     cnt ovf udf
    add("reset0",   1, 0, 0, 0,      0,      0, 0, 0);
    add("reset1",   1, 0, 0, 0,      0,      0, 0, 0);
    add("udf",      0, 0, 1, 0,      0,      0, 0, 1);
    add("udf_end",  0, 0, 0, 0,      0,      0, 0, 0);
    add("push100",  0, 1, 0, 'h100,  'h100,  1, 0, 0);
    add("push200",  0, 1, 0, 'h200,  'h200,  2, 0, 0);
    add("push300",  0, 1, 0, 'h300,  'h300,  3, 0, 0);
    add("pop_a",    0, 0, 1, 0,      'h200,  2, 0, 0);
    add("pop_b",    0, 0, 1, 0,      'h100,  1, 0, 0);
    add("pop_c",    0, 0, 1, 0,      0,      0, 0, 0);
    add("udf2",     0, 0, 1, 0,      0,      0, 0, 1);
    add("push50",   0, 1, 0, 'h50,   'h50,   1, 0, 0);
    add("push100b", 0, 1, 0, 'h100,  'h100,  2, 0, 0);
    add("push200b", 0, 1, 0, 'h200,  'h200,  3, 0, 0);
    add("replace",  0, 1, 1, 'hABC,  'hABC,  3, 0, 0);
    add("rpl_pop1", 0, 0, 1, 0,      'h100,  2, 0, 0);
    add("rpl_pop2", 0, 0, 1, 0,      'h50,   1, 0, 0);
    add("rpl_pop3", 0, 0, 1, 0,      0,      0, 0, 0);
    add("fill1",    0, 1, 0, 1,      1,      1, 0, 0);
    add("fill2",    0, 1, 0, 2,      2,      2, 0, 0);
    add("fill3",    0, 1, 0, 3,      3,      3, 0, 0);
    add("fill4",    0, 1, 0, 4,      4,      4, 0, 0);
    add("ovf5",     0, 1, 0, 5,      5,      4, 1, 0);
    add("ovf_pop4", 0, 0, 1, 0,      4,      3, 0, 0);
    add("ovf_pop3", 0, 0, 1, 0,      3,      2, 0, 0);
    add("ovf_pop2", 0, 0, 1, 0,      2,      1, 0, 0);
    add("ovf_pop0", 0, 0, 1, 0,      0,      0, 0, 0);
    add("push77",   0, 1, 0, 'h77,   'h77,   1, 0, 0);
    add("rst_push", 1, 1, 0, 'h88,   0,      0, 0, 0);
    add("idle",     0, 0, 0, 0,      0,      0, 0, 0);
`ifdef RAS_RESTORE_EN
    add("r_push1",  0, 1, 0, 'h100,  'h100,  1, 0, 0);
    add("r_push2",  0, 1, 0, 'h200,  'h200,  2, 0, 0);
    add("r_push3",  0, 1, 0, 'h300,  'h300,  3, 0, 0);
    add("r_push4",  0, 1, 0, 'h400,  'h400,  4, 0, 0);
    add("r_push5",  0, 1, 0, 'h500,  'h500,  4, 1, 0);
    add_rs("restore", 2, 2, 'h200,   'h200,  2);
    add("r_pop1",   0, 0, 1, 0,      'h100,  1, 0, 0);
    add("r_pop2",   0, 0, 1, 0,      0,      0, 0, 0);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
`ifdef RAS_RESTORE_EN
      // State here reflects the two pushes: the checkpoint to restore.
      if (vecs[i].name == "r_push3") begin
        n_chk++;
        if (ckpt_ptr_o !== ADDR'(2) || ckpt_cnt_o !== (ADDR+1)'(2)) begin
          n_fail++;
          $display("FAIL ckpt: got ptr=%0d cnt=%0d, want ptr=2 cnt=2",
                   ckpt_ptr_o, ckpt_cnt_o);
        end
      end
      restore_i     = vecs[i].rest;
      restore_ptr_i = vecs[i].rptr;
      restore_cnt_i = vecs[i].rcnt;
      restore_top_i = vecs[i].rtop;
`endif
      rst         = vecs[i].rst;
      push_i      = vecs[i].push;
      pop_i       = vecs[i].pop;
      push_addr_i = vecs[i].addr;
      x.name  = vecs[i].name;
      x.top   = vecs[i].top;
      x.cnt   = vecs[i].cnt;
      x.empty = (vecs[i].cnt == 0);
      x.full  = (vecs[i].cnt == DEPTH);
      x.ovf   = vecs[i].ovf;
      x.udf   = vecs[i].udf;
      exp_q.push_back(x);
    end
    @(negedge clk);
    rst = 1'b0; push_i = 1'b0; pop_i = 1'b0;
`ifdef RAS_RESTORE_EN
    restore_i = 1'b0;
`endif
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning BRAM entries and stack capacity (power of two).
REQ-002 SHALL have parameter WIDTH, default 32, meaning return-address width.
REQ-003 SHALL have localparam ADDR = $clog2(DEPTH).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port push_i  input  1  push push_addr_i this cycle.
REQ-007 SHALL have port push_addr_i  input  WIDTH  address to push.
REQ-008 SHALL have port pop_i  input  1  pop the top entry this cycle.
REQ-009 SHALL have port top_o  output  WIDTH  current top of stack, registered.
REQ-010 SHALL have port empty_o  output  1  count is 0.
REQ-011 SHALL have port full_o  output  1  count equals DEPTH.
REQ-012 SHALL have port count_o  output  ADDR+1  live entries.
REQ-013 SHALL have port overflow_o  output  1  one-cycle pulse, push while full.
REQ-014 SHALL have port underflow_o  output  1  one-cycle pulse, pop while empty.

Function
REQ-015 SHALL hold the top entry in register top_q and the next-on-stack in nos_q; entries below top live in a circular BRAM at index wptr-1, wptr-2, ...
REQ-016 Push only: SHALL write top_q to BRAM port A at wptr, set top_q=push_addr_i, wptr+=1 mod DEPTH, nos_q=old top_q, count+=1 (saturating at DEPTH).
REQ-017 Pop only, count>0: SHALL set top_q=nos_next, wptr-=1 mod DEPTH, count-=1, and issue BRAM port B read of wptr-2 when count>=3.
REQ-018 nos_next SHALL be BRAM dob when a port-B read was issued the previous cycle, else nos_q; back-to-back pops SHALL sustain one per cycle with zero bubbles.
REQ-019 Latched dob SHALL load nos_q the cycle after each port-B read.
REQ-020 Push and pop together: SHALL replace top_q with push_addr_i; wptr, count, nos_q and BRAM unchanged.
REQ-021 Push while full: SHALL overwrite the oldest entry (circular wrap), count stays DEPTH, overflow_o=1 next cycle.
REQ-022 Pop while empty: SHALL leave all state unchanged and pulse underflow_o next cycle.
REQ-023 After a pop reaching count=0, top_o SHALL read 0; reaching count=1, nos_q content is don't-care.
REQ-024 Port A and port B SHALL never target the same address in the same cycle; BRAM collision resolution SHALL be compiled off.
REQ-025 top_o, count_o, empty_o, full_o SHALL update exactly one cycle after the triggering request.

Reset
REQ-026 On rst: wptr=0, count_o=0, top_o=0, nos_q=0, empty_o=1, full_o=0, overflow_o=0, underflow_o=0, read-pending flag=0.
REQ-027 rst SHALL override push_i, pop_i and restore in the same cycle; BRAM contents SHALL NOT be cleared.

Configuration
REQ-028 Macro RAS_RESTORE_EN defined: SHALL add outputs ckpt_ptr_o [ADDR], ckpt_cnt_o [ADDR+1] (current wptr/count) and inputs restore_i, restore_ptr_i, restore_cnt_i, restore_top_i.
REQ-029 With RAS_RESTORE_EN, restore_i SHALL take priority over push/pop, load wptr/count/top_q from restore inputs, and issue port-B read of restore_ptr_i-1 so a pop in the next cycle is served through nos_next.
REQ-030 Without RAS_RESTORE_EN, those ports and all restore logic SHALL be absent.

Structure
REQ-031 Package ras_pkg SHALL hold the default DEPTH/WIDTH constants and the checkpoint struct type (ptr, cnt, top).
REQ-032 SHALL instantiate ras_bram as its one sub-module with RESOLVE_COLLIDE=0; all other logic inline.

Verification
REQ-033 Reset, push 0x100,0x200,0x300 -> top_o=0x300, count_o=3, empty_o=0.
REQ-034 From REQ-033, pop on three consecutive cycles -> top_o 0x200, 0x100, 0 on successive cycles, empty_o=1, no bubbles.
REQ-035 DEPTH=4, push 1..5 -> overflow_o pulses once on push 5, count_o=4, pops return 5,4,3,2.
REQ-036 Pop on empty -> underflow_o one-cycle pulse, count_o=0, top_o=0.
REQ-037 Top=0x200 with push_i=pop_i=1, push_addr_i=0xABC -> top_o=0xABC, count unchanged, no BRAM write.
REQ-038 RAS_RESTORE_EN: checkpoint at count 2, push 3 more, restore -> next-cycle pop yields checkpointed next-on-stack.
